// File: rtl/byte_mem_ctrl.sv
// Byte-addressed little-endian RAM behind valid/ready request/response channels.
// Byte enables, bounds checking, configurable read latency, one access in flight.
module byte_mem_ctrl #(
    parameter int DATA_W      = 16,
    parameter int ADDR_W      = 16,
    parameter int DEPTH_BYTES = 16384,
    parameter int READ_LAT    = 1
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_write,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [DATA_W-1:0]   req_wdata,
    input  logic [DATA_W/8-1:0] req_be,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [DATA_W-1:0]   rsp_rdata,
    output logic                rsp_err
);

    localparam int BYTES = DATA_W / 8;
    localparam int IDX_W = (DEPTH_BYTES > 1) ? $clog2(DEPTH_BYTES) : 1;
    localparam int CNT_W = 3;
    localparam logic [ADDR_W:0]  DEPTH_L   = (ADDR_W + 1)'(DEPTH_BYTES);
    localparam logic [ADDR_W:0]  SPAN_L    = (ADDR_W + 1)'(BYTES - 1);
    localparam logic [CNT_W-1:0] CNT_START = CNT_W'(READ_LAT - 1);

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   cnt, cnt_nxt;

    logic               lat_write;
    logic [ADDR_W-1:0]  lat_addr;
    logic [DATA_W-1:0]  lat_wdata;
    logic [BYTES-1:0]   lat_be;

    logic [7:0]         mem [DEPTH_BYTES];
    logic [IDX_W-1:0]   lane_idx [BYTES];
    logic [DATA_W-1:0]  rd_word;
    logic [ADDR_W:0]    end_addr;
    logic               range_err;
    logic               accept;
    logic               do_access;

    // Ready is forced low while reset is held, not just after the state settles.
    assign req_ready = (state == IDLE) && reset_n;
    assign rsp_valid = (state == RESP);
    assign accept    = req_valid && req_ready;
    assign do_access = (state == BUSY) && (cnt == '0);

    // Computed one bit wider than the address so the top of the space cannot wrap.
    assign end_addr  = {1'b0, lat_addr} + SPAN_L;
    assign range_err = (end_addr >= DEPTH_L);

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = BUSY;
                    cnt_nxt   = CNT_START;
                end
            end
            BUSY: begin
                if (cnt == '0) state_nxt = RESP;
                else           cnt_nxt   = cnt - 1'b1;
            end
            RESP: begin
                if (rsp_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            lat_write <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            lat_be    <= '0;
        end else if (accept) begin
            lat_write <= req_write;
            lat_addr  <= req_addr;
            lat_wdata <= req_wdata;
            lat_be    <= req_be;
        end
    end

    always_comb begin
        rd_word = '0;
        for (int k = 0; k < BYTES; k++) begin
            lane_idx[k] = IDX_W'(lat_addr + ADDR_W'(k));
            rd_word[8*k +: 8] = mem[lane_idx[k]];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else if (do_access) begin
            rsp_err   <= range_err;
            rsp_rdata <= (range_err || lat_write) ? '0 : rd_word;
        end else if (state == RESP && rsp_ready) begin
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end
    end

    // NOTE: the storage array has no reset; contents survive reset and start undefined.
    always_ff @(posedge clk) begin
        if (do_access && lat_write && !range_err) begin
            for (int k = 0; k < BYTES; k++) begin
                if (lat_be[k]) mem[lane_idx[k]] <= lat_wdata[8*k +: 8];
            end
        end
    end

endmodule

// File: tb/tb_byte_mem_ctrl.sv
// Directed bench for byte_mem_ctrl: a 16-bit single-cycle instance and an
// 8-bit, 256-byte, three-cycle-latency instance sharing clock and reset.
module tb_byte_mem_ctrl;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Instance A: defaults (DATA_W=16, ADDR_W=16, DEPTH 16384, READ_LAT=1)
    logic        a_req_valid = 1'b0, a_req_ready, a_req_write = 1'b0;
    logic [15:0] a_req_addr = '0, a_req_wdata = '0;
    logic [1:0]  a_req_be = '0;
    logic        a_rsp_valid, a_rsp_ready = 1'b0, a_rsp_err;
    logic [15:0] a_rsp_rdata;

    // Instance B: DATA_W=8, ADDR_W=8, DEPTH 256 (full address space), READ_LAT=3
    logic        b_req_valid = 1'b0, b_req_ready, b_req_write = 1'b0;
    logic [7:0]  b_req_addr = '0, b_req_wdata = '0;
    logic [0:0]  b_req_be = '0;
    logic        b_rsp_valid, b_rsp_ready = 1'b0, b_rsp_err;
    logic [7:0]  b_rsp_rdata;

    byte_mem_ctrl dut_a (
        .clk(clk), .reset_n(reset_n),
        .req_valid(a_req_valid), .req_ready(a_req_ready), .req_write(a_req_write),
        .req_addr(a_req_addr), .req_wdata(a_req_wdata), .req_be(a_req_be),
        .rsp_valid(a_rsp_valid), .rsp_ready(a_rsp_ready),
        .rsp_rdata(a_rsp_rdata), .rsp_err(a_rsp_err)
    );

    byte_mem_ctrl #(.DATA_W(8), .ADDR_W(8), .DEPTH_BYTES(256), .READ_LAT(3)) dut_b (
        .clk(clk), .reset_n(reset_n),
        .req_valid(b_req_valid), .req_ready(b_req_ready), .req_write(b_req_write),
        .req_addr(b_req_addr), .req_wdata(b_req_wdata), .req_be(b_req_be),
        .rsp_valid(b_rsp_valid), .rsp_ready(b_rsp_ready),
        .rsp_rdata(b_rsp_rdata), .rsp_err(b_rsp_err)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic access_a(input logic wr, input logic [15:0] addr, input logic [15:0] wd,
                            input logic [1:0] be, output logic [15:0] rd, output logic er);
        int t = 0;
        @(negedge clk);
        a_req_valid = 1'b1; a_req_write = wr; a_req_addr = addr;
        a_req_wdata = wd;   a_req_be = be;
        while (!a_req_ready && t < 20) begin @(negedge clk); t++; end
        @(posedge clk); #1;
        a_req_valid = 1'b0;
        while (!a_rsp_valid && t < 40) begin @(negedge clk); t++; end
        if (!a_rsp_valid) check("a_timeout", 64'(a_rsp_valid), 64'd1);
        rd = a_rsp_rdata; er = a_rsp_err;
        a_rsp_ready = 1'b1;
        @(posedge clk); #1;
        a_rsp_ready = 1'b0;
    endtask

    task automatic access_b(input logic wr, input logic [7:0] addr, input logic [7:0] wd,
                            input logic be, output logic [7:0] rd, output logic er);
        int t = 0;
        @(negedge clk);
        b_req_valid = 1'b1; b_req_write = wr; b_req_addr = addr;
        b_req_wdata = wd;   b_req_be = be;
        while (!b_req_ready && t < 20) begin @(negedge clk); t++; end
        @(posedge clk); #1;
        b_req_valid = 1'b0;
        while (!b_rsp_valid && t < 40) begin @(negedge clk); t++; end
        if (!b_rsp_valid) check("b_timeout", 64'(b_rsp_valid), 64'd1);
        rd = b_rsp_rdata; er = b_rsp_err;
        b_rsp_ready = 1'b1;
        @(posedge clk); #1;
        b_rsp_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [15:0] ard;
        logic [7:0]  brd;
        logic        er;

        // Reset state
        #12;
        check("rst_rsp_valid", 64'(a_rsp_valid), 64'd0);
        check("rst_rsp_rdata", 64'(a_rsp_rdata), 64'd0);
        check("rst_rsp_err",   64'(a_rsp_err),   64'd0);
        check("rst_req_ready", 64'(a_req_ready), 64'd0);
        @(negedge clk); reset_n = 1'b1;
        @(negedge clk);
        check("post_rst_ready_a", 64'(a_req_ready), 64'd1);
        check("post_rst_ready_b", 64'(b_req_ready), 64'd1);

        // Write then read back, aligned and unaligned
        access_a(1'b1, 16'h0010, 16'hBEEF, 2'b11, ard, er);
        check("wr10_err",   64'(er),  64'd0);
        check("wr10_rdata", 64'(ard), 64'd0);
        access_a(1'b1, 16'h0012, 16'h7766, 2'b11, ard, er);
        access_a(1'b0, 16'h0010, 16'h0, 2'b00, ard, er);
        check("rd10",     64'(ard), 64'hBEEF);
        check("rd10_err", 64'(er),  64'd0);
        access_a(1'b0, 16'h0011, 16'h0, 2'b00, ard, er);
        check("rd11_unaligned", 64'(ard), 64'h66BE);

        // Byte-enable merge, then an all-disabled write
        access_a(1'b1, 16'h0020, 16'h1234, 2'b11, ard, er);
        access_a(1'b1, 16'h0020, 16'hABCD, 2'b01, ard, er);
        access_a(1'b0, 16'h0020, 16'h0, 2'b00, ard, er);
        check("be_merge", 64'(ard), 64'h12CD);
        access_a(1'b1, 16'h0020, 16'hFFFF, 2'b00, ard, er);
        check("be0_err", 64'(er), 64'd0);
        access_a(1'b0, 16'h0020, 16'h0, 2'b00, ard, er);
        check("be0_unchanged", 64'(ard), 64'h12CD);

        // Bounds: last full word is legal, straddling the end is an error
        access_a(1'b1, 16'h3FFE, 16'h1122, 2'b11, ard, er);
        check("wr3ffe_err", 64'(er), 64'd0);
        access_a(1'b0, 16'h3FFF, 16'h0, 2'b00, ard, er);
        check("rd3fff_err",   64'(er),  64'd1);
        check("rd3fff_rdata", 64'(ard), 64'd0);
        access_a(1'b1, 16'h3FFF, 16'hFFFF, 2'b11, ard, er);
        check("wr3fff_err", 64'(er), 64'd1);
        access_a(1'b0, 16'h3FFE, 16'h0, 2'b00, ard, er);
        check("rd3ffe_kept", 64'(ard), 64'h1122);
        check("rd3ffe_err",  64'(er),  64'd0);
        access_a(1'b0, 16'hFFFF, 16'h0, 2'b00, ard, er);
        check("rdffff_nowrap_err", 64'(er), 64'd1);

        // 8-bit build: byte writes and the very last byte of a full address space
        access_b(1'b1, 8'h10, 8'hEF, 1'b1, brd, er);
        access_b(1'b1, 8'h11, 8'hBE, 1'b1, brd, er);
        access_b(1'b1, 8'hFF, 8'h99, 1'b1, brd, er);
        check("b_wrff_err", 64'(er), 64'd0);
        access_b(1'b0, 8'hFF, 8'h0, 1'b0, brd, er);
        check("b_rdff", 64'(brd), 64'h99);

        // Latency 3 with five cycles of response backpressure
        @(negedge clk);
        check("lat_ready_idle", 64'(b_req_ready), 64'd1);
        b_req_valid = 1'b1; b_req_write = 1'b0; b_req_addr = 8'h11;
        @(posedge clk); #1;
        b_req_valid = 1'b0;
        check("lat_ready_busy", 64'(b_req_ready), 64'd0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check($sformatf("lat_valid_%0d", i + 1), 64'(b_rsp_valid), (i == 3) ? 64'd1 : 64'd0);
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("hold_valid", 64'(b_rsp_valid), 64'd1);
            check("hold_rdata", 64'(b_rsp_rdata), 64'hBE);
            check("hold_ready", 64'(b_req_ready), 64'd0);
        end
        b_rsp_ready = 1'b1;
        @(posedge clk); #1;
        b_rsp_ready = 1'b0;
        check("hs_valid_drop", 64'(b_rsp_valid), 64'd0);
        check("hs_rdata_clr",  64'(b_rsp_rdata), 64'd0);
        check("hs_ready_back", 64'(b_req_ready), 64'd1);

        // Reset in the middle of a write: nothing commits
        access_b(1'b1, 8'h40, 8'h55, 1'b1, brd, er);
        @(negedge clk);
        b_req_valid = 1'b1; b_req_write = 1'b1; b_req_addr = 8'h40;
        b_req_wdata = 8'hAA; b_req_be = 1'b1;
        @(posedge clk); #1;
        b_req_valid = 1'b0;
        #1 reset_n = 1'b0;
        #1;
        check("midrst_valid", 64'(b_rsp_valid), 64'd0);
        check("midrst_ready", 64'(b_req_ready), 64'd0);
        @(negedge clk); reset_n = 1'b1;
        @(negedge clk);
        check("midrst_ready_back", 64'(b_req_ready), 64'd1);
        check("midrst_valid_idle", 64'(b_rsp_valid), 64'd0);
        access_b(1'b0, 8'h40, 8'h0, 1'b0, brd, er);
        check("midrst_old_data", 64'(brd), 64'h55);
        access_a(1'b0, 16'h0010, 16'h0, 2'b00, ard, er);
        check("a_mem_survives_reset", 64'(ard), 64'hBEEF);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
